mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   HI/LO multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
//   Accepts mult/div/mthi/mtlo ops with EX-stage bypassed operands, then runs a
//   fixed multi-cycle latency.
//   Drives busy to the stall unit (MultBusy) and exposes HI/LO for mfhi/mflo in EX.
// PARAMETERS
//   MULT_LAT  5   cycles busy is held for MULT/MULTU (and MADD/MSUB when enabled)
//   DIV_LAT   10  cycles busy is held for DIV/DIVU
// PORTS
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous reset, active-low (reset==0 resets at posedge clk)
//   start    in   1   op valid this cycle (EX-stage instr is mult-type, not stalled)
//   op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   rs_data  in   32  operand A (bypassed rs)
//   rt_data  in   32  operand B (bypassed rt)
//   busy     out  1   multi-cycle op in flight; HI/LO not yet valid
//   hi       out  32  committed HI register
//   lo       out  32  committed LO register
// BEHAVIOUR
//   - Reset (reset==0 at posedge): hi=0, lo=0, busy=0, counter=0, pending result cleared.
//     Applies mid-operation: in-flight op aborted, result never committed.
//   - Idle, start=1, op MULT/MULTU/DIV/DIVU:
//     - result computed from the operands sampled at that edge into a pending {hi,lo} pair.
//     - counter loads MULT_LAT or DIV_LAT; busy=1 from the next cycle.
//   - Busy: counter decrements each cycle. On the edge where the counter goes 1->0:
//     - pending pair commits to hi/lo.
//     - busy drops the same edge, so hi/lo are valid the first cycle busy==0.
//     - busy is high for exactly LAT cycles.
//   - MTHI/MTLO with start=1 while idle: hi (or lo) <= rs_data at that edge; busy stays 0.
//   - start=1 while busy: ignored entirely (stall unit guarantees this never happens;
//     the bench checks it anyway).
//   - MULT: signed 32x32->64 {hi,lo}. MULTU: unsigned.
//   - DIV: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//     0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//   - DIVU: unsigned quotient/remainder.
//   - Divide by zero: op still occupies DIV_LAT busy cycles; hi/lo left unchanged at commit.
//   - MADD/MSUB: {hi,lo} +/- signed product. The accumulator is read at commit time,
//     not at start, so a preceding MTHI/MTLO is honoured.
//   - Arithmetic is all 64-bit wraparound; no overflow flags.
//   - Registers held steady while idle; no combinational path from start to busy.
// CONFIGURATION
//   MULT_MADD_EN defined: op 6 (MADD) and 7 (MSUB) are legal and behave as above.
//   MULT_MADD_EN undefined: op 6/7 with start=1 are no-ops; busy stays 0, hi/lo unchanged.
// TESTING
//   MULT 0xFFFFFFFE * 0x00000003 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//   MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
//   DIV -7 / 2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/0 -> hi/lo unchanged.
//   MTHI 0x1234 then MTLO 0x5678 back-to-back -> hi=0x1234, lo=0x5678 next cycles;
//     busy never asserts.
//   DIV started; reset low on cycle 4 of busy -> next cycle busy=0, hi=lo=0;
//     no late commit ever follows.
//   MULT_MADD_EN: hi=0, lo=10, MADD 3*4 -> lo=22 after 5 cycles;
//     without the macro, op 6 -> lo stays 10, busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency busy window, with results committed as busy drops.
// Define MULT_MADD_EN to enable MADD (op 6) and MSUB (op 7); otherwise those ops are no-ops.
module mult_div_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    COMMIT_WRITE,
    COMMIT_NONE,
    COMMIT_ADD,
    COMMIT_SUB
  } commit_t;

  logic [CW-1:0] count_reg, count_next;
  commit_t       kind_reg, kind_next;
  logic [63:0]   pend_reg, pend_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, u_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero;

  // Low 64 bits of the product of sign-extended operands give the signed product.
  always_comb begin
    prod_s   = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
    div_zero = (rt_data == 32'd0);
    a_mag    = rs_data[31] ? -rs_data : rs_data;
    b_mag    = rt_data[31] ? -rt_data : rt_data;
    b_safe   = div_zero ? 32'd1 : b_mag;
    u_safe   = div_zero ? 32'd1 : rt_data;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    q_s      = (rs_data[31] ^ rt_data[31]) ? -q_mag : q_mag;
    r_s      = rs_data[31] ? -r_mag : r_mag;
    q_u      = rs_data / u_safe;
    r_u      = rs_data % u_safe;
  end

  always_comb begin
    count_next = count_reg;
    kind_next  = kind_reg;
    pend_next  = pend_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    if (count_reg != '0) begin
      count_next = count_reg - CW'(1);
      // Accumulating ops read HI/LO here, at commit, not when they were started.
      if (count_reg == CW'(1)) begin
        case (kind_reg)
          COMMIT_WRITE: {hi_next, lo_next} = pend_reg;
          COMMIT_ADD:   {hi_next, lo_next} = {hi_reg, lo_reg} + pend_reg;
          COMMIT_SUB:   {hi_next, lo_next} = {hi_reg, lo_reg} - pend_reg;
          default:      ;
        endcase
      end
    end else if (start) begin
      case (op)
        3'd0: begin
          pend_next  = prod_s;
          kind_next  = COMMIT_WRITE;
          count_next = CW'(MULT_LAT);
        end
        3'd1: begin
          pend_next  = prod_u;
          kind_next  = COMMIT_WRITE;
          count_next = CW'(MULT_LAT);
        end
        3'd2: begin
          pend_next  = {r_s, q_s};
          kind_next  = div_zero ? COMMIT_NONE : COMMIT_WRITE;
          count_next = CW'(DIV_LAT);
        end
        3'd3: begin
          pend_next  = {r_u, q_u};
          kind_next  = div_zero ? COMMIT_NONE : COMMIT_WRITE;
          count_next = CW'(DIV_LAT);
        end
        3'd4: hi_next = rs_data;
        3'd5: lo_next = rs_data;
`ifdef MULT_MADD_EN
        3'd6: begin
          pend_next  = prod_s;
          kind_next  = COMMIT_ADD;
          count_next = CW'(MULT_LAT);
        end
        3'd7: begin
          pend_next  = prod_s;
          kind_next  = COMMIT_SUB;
          count_next = CW'(MULT_LAT);
        end
`else
        3'd6, 3'd7: ;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
      kind_reg  <= COMMIT_NONE;
      pend_reg  <= 64'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      count_reg <= count_next;
      kind_reg  <= kind_next;
      pend_reg  <= pend_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy = (count_reg != '0);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
